// File: rtl/vga_scanout.sv
// vga_scanout: read end of the 160x120x3bpp framebuffer.
// Generates 640x480@60 VGA timing from a 50 MHz clock (25 MHz pixel tick
// derived internally), upscales the framebuffer 4x in both axes and drives
// registered colour/sync pins.
//
// Ports:
//   clk         50 MHz system clock
//   n_rst       asynchronous active-low reset
//   fb_addr     framebuffer read address (registered), A_WIDTH bits
//   fb_rdata    framebuffer read data {r,g,b}, 1-clk synchronous read
//   vga_r/g/b   pixel colour (registered)
//   vga_hsync   active-low horizontal sync (registered)
//   vga_vsync   active-low vertical sync (registered)
//   in_vblank   high while the line counter is >= 480 (registered)
//   frame_done  one-clk pulse after the last visible pixel of a frame
module vga_scanout #(
  parameter int FB_WIDTH      = 160,
  parameter int FB_SCALE_LOG2 = 2,
  parameter int A_WIDTH       = 15
) (
  input  logic               clk,
  input  logic               n_rst,
  output logic [A_WIDTH-1:0] fb_addr,
  input  logic [2:0]         fb_rdata,
  output logic               vga_r,
  output logic               vga_g,
  output logic               vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               in_vblank,
  output logic               frame_done
);

  localparam logic [9:0] H_VIS = 10'd640;
  localparam logic [9:0] H_SS  = 10'd656;
  localparam logic [9:0] H_SE  = 10'd751;
  localparam logic [9:0] H_MAX = 10'd799;
  localparam logic [9:0] V_VIS = 10'd480;
  localparam logic [9:0] V_SS  = 10'd490;
  localparam logic [9:0] V_SE  = 10'd491;
  localparam logic [9:0] V_MAX = 10'd524;

  logic               r_phase;
  logic [9:0]         r_h_cnt;
  logic [9:0]         r_v_cnt;
  logic [A_WIDTH-1:0] r_fb_addr;
  logic [2:0]         r_rgb;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_vblank;
  logic               r_frame_done;

  logic               w_tick;
  logic               w_h_wrap;
  logic [9:0]         w_h_next;
  logic [9:0]         w_v_next;
  logic               w_vis;
  logic               w_vis_next;
  logic [9:0]         w_fb_x;
  logic [9:0]         w_fb_y;
  logic [A_WIDTH-1:0] w_row_base;
  logic [A_WIDTH-1:0] w_addr_next;

  // pix_phase==1 marks the tick edge, so the first tick lands on the
  // second clk edge after reset release.
  assign w_tick   = r_phase;
  assign w_h_wrap = (r_h_cnt == H_MAX);
  assign w_h_next = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
  assign w_v_next = w_h_wrap ? ((r_v_cnt == V_MAX) ? 10'd0 : r_v_cnt + 10'd1)
                             : r_v_cnt;

  assign w_vis      = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_vis_next = (w_h_next < H_VIS) && (w_v_next < V_VIS);

  assign w_fb_x = w_h_next >> FB_SCALE_LOG2;
  assign w_fb_y = w_v_next >> FB_SCALE_LOG2;

  // Row base = y * FB_WIDTH as a shift-add over the set bits of the
  // constant (160 -> (y<<7)+(y<<5)); no multiplier is inferred.
  always_comb begin
    w_row_base = '0;
    for (int b = 0; b < 31; b++) begin
      if (((FB_WIDTH >> b) & 1) != 0)
        w_row_base = w_row_base + (A_WIDTH'(w_fb_y) << b);
    end
  end

  assign w_addr_next = w_row_base + A_WIDTH'(w_fb_x);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase      <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_fb_addr    <= '0;
      r_rgb        <= '0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_vblank     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_phase      <= ~r_phase;
      r_frame_done <= 1'b0;
      if (w_tick) begin
        r_h_cnt <= w_h_next;
        if (w_h_wrap)
          r_v_cnt <= w_v_next;
        // Pins use the pre-increment position; fb_rdata here was fetched
        // on the non-tick edge from the address set at the previous tick.
        r_rgb        <= w_vis ? fb_rdata : 3'b000;
        r_hsync      <= !((r_h_cnt >= H_SS) && (r_h_cnt <= H_SE));
        r_vsync      <= !((r_v_cnt >= V_SS) && (r_v_cnt <= V_SE));
        r_vblank     <= (r_v_cnt >= V_VIS);
        r_fb_addr    <= w_vis_next ? w_addr_next : '0;
        r_frame_done <= (r_h_cnt == H_VIS - 10'd1) && (r_v_cnt == V_VIS - 10'd1);
      end
    end
  end

  assign fb_addr    = r_fb_addr;
  assign vga_r      = r_rgb[2];
  assign vga_g      = r_rgb[1];
  assign vga_b      = r_rgb[0];
  assign vga_hsync  = r_hsync;
  assign vga_vsync  = r_vsync;
  assign in_vblank  = r_vblank;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout. Pixel positions are modelled as a linear index
// (one per tick) mapped onto (h, v) with plain arithmetic; the line counter
// is jumped forward twice with force/release in phase B so vertical
// blanking, vsync and frame_done are reached in a short run.
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [14:0] fb_addr;
  logic [2:0]  fb_rdata;
  logic        vga_r, vga_g, vga_b, vga_hsync, vga_vsync, in_vblank, frame_done;

  vga_scanout #(.FB_WIDTH(160), .FB_SCALE_LOG2(2), .A_WIDTH(15)) dut (
    .clk(clk), .n_rst(n_rst), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .in_vblank(in_vblank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // synchronous-read sram model
  logic [2:0] mem [0:32767];
  always @(posedge clk) fb_rdata <= mem[fb_addr];

  int n_pass = 0;
  int n_total = 0;
  bit phase_b = 1'b0;
  int hs_low, vs_low, vb_hi, fd_cnt;

  typedef struct {
    bit pb;
    int t;
    int addr;
  } addr_vec_t;
  addr_vec_t tbl [14];

  // Phase B: line 0 at v=0, forced to 478 so line L (1..15) is 478+L,
  // then forced to 521 during v=493 so lines continue 522,523,524,0,1...
  function automatic int line_v(int L);
    if (!phase_b) return L % 525;
    if (L == 0) return 0;
    if (L <= 15) return 478 + L;
    return (506 + L) % 525;
  endfunction

  // Expected {fb_addr, rgb, hsync, vsync, vblank, frame_done} after the
  // k-th clk edge since reset release. Tick n happens at edge 2n; after it
  // the counter sits on pixel index n and the pins show pixel n-1.
  function automatic logic [20:0] model(int k);
    int n, h, v;
    logic [14:0] a;
    logic [2:0] c;
    logic hs, vs, vb, fd;
    n = k / 2;
    h = n % 800;
    v = line_v(n / 800);
    a = (h < 640 && v < 480) ? 15'((v / 4) * 160 + h / 4) : 15'd0;
    c = 3'b000; hs = 1'b1; vs = 1'b1; vb = 1'b0; fd = 1'b0;
    if (n > 0) begin
      h = (n - 1) % 800;
      v = line_v((n - 1) / 800);
      if (h < 640 && v < 480) c = mem[(v / 4) * 160 + h / 4];
      hs = !(h >= 656 && h <= 751);
      vs = !(v >= 490 && v <= 491);
      vb = (v >= 480);
      fd = (k % 2 == 0) && (h == 639) && (v == 479);
    end
    return {a, c, hs, vs, vb, fd};
  endfunction

  function automatic logic [20:0] pins();
    return {fb_addr, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, in_vblank, frame_done};
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s k=%0d got %h want %h", name, k, act, exp);
  endtask

  task automatic run(input int kmax);
    logic [20:0] p;
    hs_low = 0; vs_low = 0; vb_hi = 0; fd_cnt = 0;
    check("release", 0, 32'(pins()), 32'(model(0)));
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk);
      @(negedge clk);
      p = pins();
      check(phase_b ? "scan_b" : "scan_a", k, 32'(p), 32'(model(k)));
      for (int j = 0; j < 14; j++)
        if (tbl[j].pb == phase_b && k == 2 * tbl[j].t)
          check("addr_tbl", k, 32'(fb_addr), 32'(tbl[j].addr));
      // line 2 of phase A spans samples 3202..4801
      if (!phase_b && k >= 3202 && k <= 4801 && !vga_hsync) hs_low++;
      if (!vga_vsync) vs_low++;
      if (in_vblank) vb_hi++;
      if (frame_done) fd_cnt++;
      if (phase_b && k == 1401) begin        // line 0, h=700
        force dut.r_v_cnt = 10'd478;
        #1 release dut.r_v_cnt;
      end
      if (phase_b && k == 25401) begin       // line 15 (v=493), h=700
        force dut.r_v_cnt = 10'd521;
        #1 release dut.r_v_cnt;
      end
    end
  endtask

  localparam logic [20:0] RST_PINS = {15'd0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    tbl[0]  = '{0, 0,    0};
    tbl[1]  = '{0, 3,    0};
    tbl[2]  = '{0, 4,    1};
    tbl[3]  = '{0, 636,  159};
    tbl[4]  = '{0, 639,  159};
    tbl[5]  = '{0, 640,  0};
    tbl[6]  = '{0, 799,  0};
    tbl[7]  = '{0, 2400, 0};
    tbl[8]  = '{0, 3200, 160};
    tbl[9]  = '{0, 3204, 161};
    tbl[10] = '{0, 3839, 319};
    tbl[11] = '{1, 800,  19040};
    tbl[12] = '{1, 1439, 19199};
    tbl[13] = '{1, 1440, 0};

    for (int i = 0; i < 32768; i++) mem[i] = 3'(i % 8);

    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hold", 0, 32'(pins()), 32'(RST_PINS));

    // Phase A: first frame up to (h=300, v=5), colour = addr%8
    n_rst = 1'b1;
    run(8601);
    check("hsync_low_clks", 0, 32'(hs_low), 32'd192);

    n_rst = 1'b0;
    #1;
    check("async_reset", 0, 32'(pins()), 32'(RST_PINS));
    repeat (2) @(negedge clk);
    check("reset_held", 0, 32'(pins()), 32'(RST_PINS));

    // Phase B: restart from (0,0) with random framebuffer contents
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom_range(0, 7));
    phase_b = 1'b1;
    n_rst = 1'b1;
    run(33602);
    check("vsync_low_clks", 0, 32'(vs_low), 32'd3200);
    check("vblank_clks", 0, 32'(vb_hi), 32'd27200);
    check("frame_done_pulses", 0, 32'(fd_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
